// File: rtl/fmps_link_tx.sv
// FMPS link transmitter.
// Formats one FMPS status record into a two-beat AXI-Stream packet (header, data)
// and drives it onto an Aurora TX link. Everything runs in the auClk domain.
//
// Ports:
//   auClk, auResetN      clock, asynchronous active-low reset
//   auChannelUp          link up; low aborts any packet and flushes the buffer
//   auFAstrobe           FA cycle marker; advances cycleCounter, clears per-cycle count
//   txInhibit            level; requests are dropped while high
//   sendStrobe           one-cycle request, samples fmpsIndex/fmpsData/flags
//   TX_tdata/tvalid/tlast/tready   AXI-Stream master
//   busy                 transmitter or buffer occupied
//   cycleCounter         FA cycle count
//   pktCount, dropCount  packets sent (wraps), requests dropped (saturates)
//   overrun              sticky, a request was lost to a full buffer
module fmps_link_tx #(
  parameter int unsigned INDEX_WIDTH        = 5,
  parameter logic [15:0] HEADER_MAGIC       = 16'hB6CF,
  parameter int unsigned MAX_PKTS_PER_CYCLE = 32,
  parameter int unsigned CNT_WIDTH          = 16
) (
  input  logic                   auClk,
  input  logic                   auResetN,
  input  logic                   auChannelUp,
  input  logic                   auFAstrobe,
  input  logic                   txInhibit,
  input  logic                   sendStrobe,
  input  logic [INDEX_WIDTH-1:0] fmpsIndex,
  input  logic [15:0]            fmpsData,
  input  logic                   flagFMPS2CC,
  input  logic                   flagCC2CC,
  output logic [31:0]            TX_tdata,
  output logic                   TX_tvalid,
  output logic                   TX_tlast,
  input  logic                   TX_tready,
  output logic                   busy,
  output logic [7:0]             cycleCounter,
  output logic [CNT_WIDTH-1:0]   pktCount,
  output logic [CNT_WIDTH-1:0]   dropCount,
  output logic                   overrun
);

  localparam int unsigned PcW = $clog2(MAX_PKTS_PER_CYCLE + 1);

  typedef enum logic [1:0] {StIdle, StHeader, StData} state_e;

  // Index is stored zero-extended to the full 5-bit field.
  typedef struct packed {
    logic [4:0]  idx;
    logic [15:0] data;
    logic        flag_fmps2cc;
    logic        flag_cc2cc;
    logic [7:0]  cyc;
  } pkt_t;

  state_e               state_q, state_d;
  pkt_t                 cur_q, cur_d;
  pkt_t                 pend_q, pend_d;
  pkt_t                 req_pkt;
  logic                 cap_valid_q, cap_valid_d;   // cur holds a packet not yet started
  logic                 pend_valid_q, pend_valid_d;
  logic [PcW-1:0]       pkts_in_cyc_q, pkts_in_cyc_d;
  logic [7:0]           cycle_counter_q, cycle_counter_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                 overrun_q, overrun_d;
  logic [31:0]          tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;

  logic req, limit_hit, to_pend, full_block, accept, drop;

  always_comb begin
    req_pkt                        = '0;
    req_pkt.idx[INDEX_WIDTH-1:0]   = fmpsIndex;
    req_pkt.data                   = fmpsData;
    req_pkt.flag_fmps2cc           = flagFMPS2CC;
    req_pkt.flag_cc2cc             = flagCC2CC;
    req_pkt.cyc                    = cycle_counter_q;  // value before any same-cycle FA step
  end

  always_comb begin
    req        = sendStrobe && auChannelUp;
    limit_hit  = (32'(pkts_in_cyc_q) >= MAX_PKTS_PER_CYCLE);
    // A request can start directly only when the transmitter is completely free.
    to_pend    = (state_q != StIdle) || cap_valid_q;
    full_block = to_pend && pend_valid_q;
    accept     = req && !txInhibit && !limit_hit && !full_block;
    drop       = req && !accept;
  end

  always_comb begin
    state_d         = state_q;
    cur_d           = cur_q;
    pend_d          = pend_q;
    cap_valid_d     = cap_valid_q;
    pend_valid_d    = pend_valid_q;
    pkt_count_d     = pkt_count_q;
    drop_count_d    = drop_count_q;
    overrun_d       = overrun_q;
    cycle_counter_d = auFAstrobe ? cycle_counter_q + 8'd1 : cycle_counter_q;

    // Limit check above used the pre-clear count; an accepted request opens the new cycle.
    if (auFAstrobe) begin
      pkts_in_cyc_d = accept ? PcW'(1) : '0;
    end else begin
      pkts_in_cyc_d = accept ? pkts_in_cyc_q + PcW'(1) : pkts_in_cyc_q;
    end

    if (drop) begin
      if (drop_count_q != '1) drop_count_d = drop_count_q + CNT_WIDTH'(1);
      if (full_block && !txInhibit && !limit_hit) overrun_d = 1'b1;
    end

    if (accept) begin
      if (to_pend) begin
        pend_d       = req_pkt;
        pend_valid_d = 1'b1;
      end else begin
        cur_d        = req_pkt;
        cap_valid_d  = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (cap_valid_q) begin
          state_d     = StHeader;
          cap_valid_d = 1'b0;
        end
      end
      StHeader: begin
        if (TX_tready) state_d = StData;
      end
      StData: begin
        if (TX_tready) begin
          pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
          if (pend_valid_q) begin
            // Back-to-back: buffered packet goes straight out, no idle beat.
            cur_d        = pend_q;
            pend_valid_d = 1'b0;
            state_d      = StHeader;
          end else begin
            state_d = StIdle;
            // A request landing on the final beat would otherwise sit in the
            // buffer with nothing to drain it; start it through the idle path.
            if (accept) begin
              cur_d        = req_pkt;
              cap_valid_d  = 1'b1;
              pend_valid_d = 1'b0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (!auChannelUp) begin
      state_d      = StIdle;
      cap_valid_d  = 1'b0;
      pend_valid_d = 1'b0;
      pkt_count_d  = pkt_count_q;
    end
  end

  // Outputs are registered from the next state so they change only on an edge.
  always_comb begin
    tvalid_d = (state_d != StIdle);
    tlast_d  = (state_d == StData);
    unique case (state_d)
      StHeader: tdata_d = {HEADER_MAGIC, 1'b0, cur_d.idx, 10'b0};
      StData:   tdata_d = {cur_d.flag_fmps2cc, cur_d.flag_cc2cc, 1'b0, cur_d.idx,
                           cur_d.data, cur_d.cyc};
      default:  tdata_d = '0;
    endcase
  end

  always_ff @(posedge auClk or negedge auResetN) begin
    if (!auResetN) begin
      state_q         <= StIdle;
      cur_q           <= '0;
      pend_q          <= '0;
      cap_valid_q     <= 1'b0;
      pend_valid_q    <= 1'b0;
      pkts_in_cyc_q   <= '0;
      cycle_counter_q <= '0;
      pkt_count_q     <= '0;
      drop_count_q    <= '0;
      overrun_q       <= 1'b0;
      tdata_q         <= '0;
      tvalid_q        <= 1'b0;
      tlast_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_q           <= cur_d;
      pend_q          <= pend_d;
      cap_valid_q     <= cap_valid_d;
      pend_valid_q    <= pend_valid_d;
      pkts_in_cyc_q   <= pkts_in_cyc_d;
      cycle_counter_q <= cycle_counter_d;
      pkt_count_q     <= pkt_count_d;
      drop_count_q    <= drop_count_d;
      overrun_q       <= overrun_d;
      tdata_q         <= tdata_d;
      tvalid_q        <= tvalid_d;
      tlast_q         <= tlast_d;
    end
  end

  assign TX_tdata     = tdata_q;
  assign TX_tvalid    = tvalid_q;
  assign TX_tlast     = tlast_q;
  assign busy         = (state_q != StIdle) || cap_valid_q || pend_valid_q;
  assign cycleCounter = cycle_counter_q;
  assign pktCount     = pkt_count_q;
  assign dropCount    = drop_count_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_fmps_link_tx.sv
// Directed bench for fmps_link_tx, built with a per-cycle limit of 4 packets.
module tb_fmps_link_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chan_up, fa, inhibit, strobe, f1, f2, tready;
  logic [4:0]  idx;
  logic [15:0] data;
  logic [31:0] tdata;
  logic        tvalid, tlast, busy, ovr;
  logic [7:0]  cyc;
  logic [15:0] pkt, drp;

  always #5 clk = ~clk;

  fmps_link_tx #(
    .INDEX_WIDTH        (5),
    .HEADER_MAGIC       (16'hB6CF),
    .MAX_PKTS_PER_CYCLE (4),
    .CNT_WIDTH          (16)
  ) dut (
    .auClk        (clk),
    .auResetN     (rst_n),
    .auChannelUp  (chan_up),
    .auFAstrobe   (fa),
    .txInhibit    (inhibit),
    .sendStrobe   (strobe),
    .fmpsIndex    (idx),
    .fmpsData     (data),
    .flagFMPS2CC  (f1),
    .flagCC2CC    (f2),
    .TX_tdata     (tdata),
    .TX_tvalid    (tvalid),
    .TX_tlast     (tlast),
    .TX_tready    (tready),
    .busy         (busy),
    .cycleCounter (cyc),
    .pktCount     (pkt),
    .dropCount    (drp),
    .overrun      (ovr)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Beat monitor, sampled mid-cycle.
  logic [32:0] beats[$];
  int          beat_cyc[$];
  int          cyc_n        = 0;
  int          stall_viol   = 0;
  int          valid_cycles = 0;
  logic        prev_stall   = 1'b0;
  logic [32:0] prev_beat    = '0;
  logic        prev_up      = 1'b0;

  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (tvalid) valid_cycles <= valid_cycles + 1;
    if (rst_n && tvalid && tready) begin
      beats.push_back({tlast, tdata});
      beat_cyc.push_back(cyc_n);
    end
    if (prev_stall && rst_n) begin
      if (tvalid) begin
        if ({tlast, tdata} !== prev_beat) stall_viol <= stall_viol + 1;
      end else if (prev_up) begin
        stall_viol <= stall_viol + 1;
      end
    end
    prev_stall <= rst_n && tvalid && !tready;
    prev_beat  <= {tlast, tdata};
    prev_up    <= chan_up;
  end

  logic rand_ready = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [4:0] i, input logic [15:0] d, input logic a, input logic b);
    idx = i; data = d; f1 = a; f2 = b; strobe = 1'b1;
    step();
    strobe = 1'b0;
  endtask

  task automatic fa_pulse();
    fa = 1'b1;
    step();
    fa = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (beats.size() < n && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, 64'(beats.size() >= n), 64'd1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k = 0;
    while (!tvalid && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, 64'(tvalid), 64'd1);
  endtask

  int b0;
  int vc0;

  initial begin
    rst_n = 1'b0; chan_up = 1'b0; fa = 1'b0; inhibit = 1'b0; strobe = 1'b0;
    f1 = 1'b0; f2 = 1'b0; idx = '0; data = '0; tready = 1'b1;
    steps(3);
    check_eq("rst_tvalid", 64'(tvalid), 64'd0);
    check_eq("rst_tlast",  64'(tlast),  64'd0);
    check_eq("rst_tdata",  64'(tdata),  64'd0);
    check_eq("rst_pkt",    64'(pkt),    64'd0);
    check_eq("rst_drop",   64'(drp),    64'd0);
    check_eq("rst_ovr",    64'(ovr),    64'd0);
    check_eq("rst_cyc",    64'(cyc),    64'd0);
    check_eq("rst_busy",   64'(busy),   64'd0);
    rst_n = 1'b1; chan_up = 1'b1;
    steps(2);

    // Basic packet after two FA strobes.
    fa_pulse();
    fa_pulse();
    check_eq("cyc_after_2fa", 64'(cyc), 64'd2);
    b0 = beats.size();
    send(5'd3, 16'hCACA, 1'b0, 1'b0);
    check_eq("lat_n1_tvalid", 64'(tvalid), 64'd0);
    step();
    check_eq("lat_n2_tvalid", 64'(tvalid), 64'd1);
    check_eq("lat_n2_tdata",  64'(tdata),  64'hB6CF0C00);
    check_eq("busy_in_pkt",   64'(busy),   64'd1);
    wait_beats(b0 + 2, 10, "basic_wait");
    steps(2);
    check_eq("basic_hdr",  64'(beats[b0]),     {31'd0, 33'h0_B6CF0C00});
    check_eq("basic_data", 64'(beats[b0 + 1]), {31'd0, 33'h1_03CACA02});
    check_eq("basic_pkt",  64'(pkt),    64'd1);
    check_eq("basic_idle", 64'(tvalid), 64'd0);

    // Same request under random backpressure.
    b0 = beats.size();
    rand_ready = 1'b1;
    send(5'd3, 16'hCACA, 1'b0, 1'b0);
    wait_beats(b0 + 2, 200, "bp_wait");
    rand_ready = 1'b0;
    tready = 1'b1;
    steps(4);
    check_eq("bp_handshakes", 64'(beats.size()), 64'(b0 + 2));
    check_eq("bp_hdr",  64'(beats[b0]),     {31'd0, 33'h0_B6CF0C00});
    check_eq("bp_data", 64'(beats[b0 + 1]), {31'd0, 33'h1_03CACA02});
    check_eq("bp_pkt",  64'(pkt), 64'd2);

    // Per-cycle limit of 4: six spaced requests in one FA cycle.
    fa_pulse();
    b0 = beats.size();
    for (int i = 0; i < 6; i++) begin
      send(5'(i), 16'hA000 + 16'(i), 1'b0, 1'b0);
      steps(15);
    end
    check_eq("lim_beats", 64'(beats.size()), 64'(b0 + 8));
    check_eq("lim_hdr3",  64'(beats[b0 + 6]), {31'd0, 33'h0_B6CF0C00});
    check_eq("lim_data3", 64'(beats[b0 + 7]), {31'd0, 33'h1_03A00303});
    check_eq("lim_pkt",   64'(pkt), 64'd6);
    check_eq("lim_drop",  64'(drp), 64'd2);
    check_eq("lim_ovr",   64'(ovr), 64'd0);

    // Request coinciding with FA while at the limit: judged on the old count.
    idx = 5'd9; data = 16'h1234; f1 = 1'b0; f2 = 1'b0;
    strobe = 1'b1; fa = 1'b1;
    step();
    strobe = 1'b0; fa = 1'b0;
    steps(2);
    check_eq("limfa_drop",    64'(drp),    64'd3);
    check_eq("limfa_cyc",     64'(cyc),    64'd4);
    check_eq("limfa_novalid", 64'(tvalid), 64'd0);

    b0 = beats.size();
    send(5'd9, 16'h1234, 1'b0, 1'b0);
    wait_beats(b0 + 2, 20, "newcyc_wait");
    steps(2);
    check_eq("newcyc_hdr",  64'(beats[b0]),     {31'd0, 33'h0_B6CF2400});
    check_eq("newcyc_data", 64'(beats[b0 + 1]), {31'd0, 33'h1_09123404});
    check_eq("newcyc_pkt",  64'(pkt), 64'd7);

    // Accepted request on an FA edge carries the pre-increment cycle value.
    b0 = beats.size();
    idx = 5'd4; data = 16'h5555; strobe = 1'b1; fa = 1'b1;
    step();
    strobe = 1'b0; fa = 1'b0;
    check_eq("samefa_cyc", 64'(cyc), 64'd5);
    wait_beats(b0 + 2, 20, "samefa_wait");
    steps(2);
    check_eq("samefa_data", 64'(beats[b0 + 1]), {31'd0, 33'h1_04555504});
    check_eq("samefa_pkt",  64'(pkt), 64'd8);

    // Back-to-back: three requests on consecutive cycles.
    fa_pulse();
    b0 = beats.size();
    idx = 5'd1; data = 16'h1111; f1 = 1'b1; f2 = 1'b0; strobe = 1'b1;
    step();
    idx = 5'd2; data = 16'h2222; f1 = 1'b0; f2 = 1'b1;
    step();
    idx = 5'd7; data = 16'h7777; f1 = 1'b0; f2 = 1'b0;
    step();
    strobe = 1'b0;
    wait_beats(b0 + 4, 30, "b2b_wait");
    steps(3);
    check_eq("b2b_beats", 64'(beats.size()),  64'(b0 + 4));
    check_eq("b2b_hdr1",  64'(beats[b0]),     {31'd0, 33'h0_B6CF0400});
    check_eq("b2b_data1", 64'(beats[b0 + 1]), {31'd0, 33'h1_81111106});
    check_eq("b2b_hdr2",  64'(beats[b0 + 2]), {31'd0, 33'h0_B6CF0800});
    check_eq("b2b_data2", 64'(beats[b0 + 3]), {31'd0, 33'h1_42222206});
    check_eq("b2b_nogap", 64'(beat_cyc[b0 + 3] - beat_cyc[b0]), 64'd3);
    check_eq("b2b_drop",  64'(drp), 64'd4);
    check_eq("b2b_ovr",   64'(ovr), 64'd1);
    check_eq("b2b_pkt",   64'(pkt), 64'd10);

    // Inhibit drops without transmitting.
    vc0 = valid_cycles;
    inhibit = 1'b1;
    send(5'd5, 16'h0001, 1'b0, 1'b0);
    inhibit = 1'b0;
    steps(5);
    check_eq("inh_drop",    64'(drp), 64'd5);
    check_eq("inh_novalid", 64'(valid_cycles - vc0), 64'd0);

    // Channel loss while the data beat is stalled.
    tready = 1'b0;
    send(5'd5, 16'h5A5A, 1'b0, 1'b0);
    wait_valid(10, "cl_wait_hdr");
    check_eq("cl_hdr_tlast", 64'(tlast), 64'd0);
    tready = 1'b1;
    step();
    tready = 1'b0;
    steps(2);
    check_eq("cl_data_held", 64'({tvalid, tlast}), 64'd3);
    chan_up = 1'b0;
    step();
    check_eq("cl_tvalid", 64'(tvalid), 64'd0);
    check_eq("cl_pkt",    64'(pkt),    64'd10);
    check_eq("cl_drop",   64'(drp),    64'd5);
    check_eq("cl_busy",   64'(busy),   64'd0);
    b0 = beats.size();
    send(5'd6, 16'h6666, 1'b0, 1'b0);
    steps(3);
    check_eq("down_drop",   64'(drp),          64'd5);
    check_eq("down_tvalid", 64'(tvalid),       64'd0);
    check_eq("down_beats",  64'(beats.size()), 64'(b0));
    fa_pulse();
    check_eq("down_cyc",    64'(cyc),          64'd7);
    chan_up = 1'b1;
    tready = 1'b1;
    steps(2);

    // Asynchronous reset during the header beat.
    tready = 1'b0;
    send(5'd8, 16'h0F0F, 1'b1, 1'b1);
    wait_valid(10, "ar_wait_hdr");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_tvalid", 64'(tvalid), 64'd0);
    check_eq("ar_counts", 64'({pkt, drp, ovr, cyc}), 64'd0);
    steps(2);
    rst_n = 1'b1;
    tready = 1'b1;
    steps(2);
    b0 = beats.size();
    send(5'd2, 16'hBEEF, 1'b0, 1'b0);
    wait_beats(b0 + 2, 20, "ar_wait");
    steps(2);
    check_eq("ar_hdr",  64'(beats[b0]),     {31'd0, 33'h0_B6CF0800});
    check_eq("ar_data", 64'(beats[b0 + 1]), {31'd0, 33'h1_02BEEF00});
    check_eq("ar_pkt",  64'(pkt), 64'd1);

    check_eq("stall_stable", 64'(stall_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
